// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_if
//  Description : Request/response bundle between the EX stage and the
//                iterative multiply/divide unit (HI/LO owner).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues requests, observes status and HI/LO
  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  // Unit side
  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative multiply/divide unit for the EX stage. Owns HI/LO,
//                runs MULT/MULTU in MUL_CYCLES cycles and DIV/DIVU with a
//                restoring radix-2 divider (32 iterations + 1 sign fix-up).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  mdu_bus
);

  localparam int CNT_W = ($clog2(MUL_CYCLES) > 6) ? $clog2(MUL_CYCLES) : 6;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(32);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;       // multiplicand
  logic [31:0]      b_q, b_d;       // multiplier, or divisor magnitude
  logic [63:0]      rq_q, rq_d;     // remainder (upper) / quotient (lower)
  logic             sgn_q, sgn_d;   // signed multiply
  logic             qneg_q, qneg_d; // negate quotient at fix-up
  logic             rneg_q, rneg_d; // negate remainder at fix-up
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  logic        w_accept;
  logic        w_op_signed;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [32:0] w_top;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_step;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  // Request qualification and operand conditioning
  always_comb begin
    w_accept    = mdu_bus.start && (state_q == S_IDLE) && !mdu_bus.flush &&
                  !(mdu_bus.op[2] && mdu_bus.op[1]);
    w_op_signed = ~mdu_bus.op[0];
    w_abs_a     = (w_op_signed && mdu_bus.a[31]) ? (32'd0 - mdu_bus.a) : mdu_bus.a;
    w_abs_b     = (w_op_signed && mdu_bus.b[31]) ? (32'd0 - mdu_bus.b) : mdu_bus.b;
  end

  // Datapath: full 64-bit product, one restoring divide step, sign fix-up.
  // The shifted partial remainder is 33 bits wide because an unsigned divisor
  // can be >= 2^31, so the remainder may carry out of the upper half.
  always_comb begin
    w_ext_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    w_ext_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    w_prod  = w_ext_a * w_ext_b;
    w_top   = rq_q[63:31];
    w_ge    = (w_top >= {1'b0, b_q});
    w_diff  = w_top[31:0] - b_q;
    w_step  = w_ge ? {w_diff, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
    w_quo   = qneg_q ? (32'd0 - rq_q[31:0])  : rq_q[31:0];
    w_rem   = rneg_q ? (32'd0 - rq_q[63:32]) : rq_q[63:32];
  end

  // Next-state and register-update decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rq_d    = rq_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (mdu_bus.op)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = MUL_LOAD;
              a_d     = mdu_bus.a;
              b_d     = mdu_bus.b;
              sgn_d   = w_op_signed;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = '0;
              b_d     = w_abs_b;
              rq_d    = {32'd0, w_abs_a};
              sgn_d   = w_op_signed;
              qneg_d  = w_op_signed && (mdu_bus.a[31] ^ mdu_bus.b[31]);
              rneg_d  = w_op_signed && mdu_bus.a[31];
            end
            OP_MTHI: hi_d = mdu_bus.a;
            OP_MTLO: lo_d = mdu_bus.a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (mdu_bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          hi_d    = w_prod[63:32];
          lo_d    = w_prod[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (mdu_bus.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DIV_LAST) begin
          hi_d    = w_rem;
          lo_d    = w_quo;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          rq_d  = w_step;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and architectural registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rq_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rq_q    <= rq_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    mdu_bus.busy = (state_q != S_IDLE);
    mdu_bus.done = done_q;
    mdu_bus.hi   = hi_q;
    mdu_bus.lo   = lo_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Self-checking bench for ex_muldiv: directed corner cases
//                plus random operations against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 33;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  ex_muldiv_if bus ();

  ex_muldiv #(.MUL_CYCLES(MUL_CYCLES)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .mdu_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi,lo} from plain arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] hi,
                                            input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [31:0]     qm, rm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2: begin
        if (b == 32'd0) begin
          qm = 32'hFFFF_FFFF;
          rm = a[31] ? (32'd0 - a) : a;
          return {a[31] ? (32'd0 - rm) : rm, a[31] ? (32'd0 - qm) : qm};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] op);
    if (op <= 3'd1) return MUL_CYCLES;
    if (op <= 3'd3) return DIV_CYCLES;
    return 0;
  endfunction

  // Issue one request from idle and check latency, done pulse and HI/LO
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    logic [63:0] exp;
    int          ncyc;
    int          cyc;
    exp  = ref_model(op, a, b, m_hi, m_lo);
    ncyc = exp_cycles(op);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'(ncyc));
    check({tag, " done"}, {63'd0, bus.done}, {63'd0, ncyc != 0});
    check({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    if (ncyc != 0) begin
      tick();
      check({tag, " done_single"}, {63'd0, bus.done}, 64'd0);
    end
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return allow_zero ? 32'd0 : 32'd1;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    int cyc;
    int dones;
    n_chk     = 0;
    n_fail    = 0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    bus.flush = 1'b0;
    tick();
    tick();
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a divide clears everything without a clock edge
    do_op("mthi pre", 3'd4, 32'h1234_5678, 32'd0);
    do_op("mtlo pre", 3'd5, 32'h9ABC_DEF0, 32'd0);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd1000; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("middiv busy", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("async rst busy", {63'd0, bus.busy}, 64'd0);
    check("async rst hilo", {bus.hi, bus.lo}, 64'd0);
    #1;
    rst  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    tick();
    do_op("mtlo 5", 3'd5, 32'd5, 32'd0);

    // Directed arithmetic cases
    do_op("mult -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult -3*7 exact", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
    check("multu exact", {m_hi, m_lo}, 64'h0000_0001_FFFF_FFFE);
    do_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 exact", {m_hi, m_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu 100/7", 3'd3, 32'd100, 32'd7);
    check("divu 100/7 exact", {m_hi, m_lo}, {32'd2, 32'd14});
    do_op("divu 9/0", 3'd3, 32'd9, 32'd0);
    check("divu 9/0 exact", {m_hi, m_lo}, {32'd9, 32'hFFFF_FFFF});
    do_op("div 7/0", 3'd2, 32'd7, 32'd0);
    check("div 7/0 exact", {m_hi, m_lo}, {32'd7, 32'hFFFF_FFFF});
    do_op("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div ovf exact", {m_hi, m_lo}, {32'd0, 32'h8000_0000});
    do_op("divu big", 3'd3, 32'hFFFF_FFFF, 32'h8000_0001);
    do_op("nop 110", 3'd6, 32'h1111_1111, 32'd2);

    // Flush at divide cycle 10 leaves HI/LO alone and produces no done
    do_op("mthi AA", 3'd4, 32'hAA, 32'd0);
    do_op("mtlo BB", 3'd5, 32'hBB, 32'd0);
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd50; bus.b = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", {63'd0, bus.busy}, 64'd0);
    check("flush hilo", {bus.hi, bus.lo}, {32'hAA, 32'hBB});
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("flush no done", 64'(dones), 64'd0);

    // Flush and start together: nothing accepted
    bus.flush = 1'b1; bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD;
    tick();
    check("flush+mthi hi", {32'd0, bus.hi}, {32'd0, m_hi});
    bus.op = 3'd3; bus.a = 32'd10; bus.b = 32'd3;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    check("flush+divu busy", {63'd0, bus.busy}, 64'd0);
    tick();
    check("flush+divu idle", {63'd0, bus.busy}, 64'd0);

    // Start held across busy with a different op
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'hFFFF_FFFD; bus.b = 32'd7;
    tick();
    bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check("held first cycles", 64'(cyc), 64'(MUL_CYCLES));
    check("held first done", {63'd0, bus.done}, 64'd1);
    check("held first hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check("held second cycles", 64'(cyc), 64'(DIV_CYCLES));
    check("held second done", {63'd0, bus.done}, 64'd1);
    check("held second hilo", {bus.hi, bus.lo}, {32'd2, 32'd14});
    m_hi = 32'd2;
    m_lo = 32'd14;
    tick();

    // Random operations
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick(1'b1);
      rb  = pick(1'b1);
      do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
